// File: rtl/dma_channel_arbiter.sv
// Four-channel DREQ arbiter and DACK sequencer for an 8237A-style DMA controller.
// Optional rotating priority is enabled by defining DMA_ROTATE_PRIORITY_EN.
module dma_channel_arbiter #(
    parameter int NCH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NCH-1:0]         DREQ,
    input  logic [7:0]             commandReg,
    input  logic [NCH-1:0]         maskReg,
    input  logic [NCH-1:0]         requestReg,
    input  logic                   HLDA,
    input  logic                   cycleDone,
    output logic                   HRQ,
    output logic [NCH-1:0]         DACK,
    output logic [NCH-1:0]         validDreq,
    output logic [$clog2(NCH)-1:0] activeCh,
    output logic                   busy
);
    localparam int PW = $clog2(NCH);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        SERVICE = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t          state;
    logic [NCH-1:0]  dreq_q;
    logic [NCH-1:0]  req;
    logic [PW-1:0]   grant_ch;
    logic [PW-1:0]   prio_ptr;
    logic [PW-1:0]   pick_ch;
    logic            pick_found;
    logic            unused_cmd;

    always_ff @(posedge CLK) begin
        if (!RESET_N) dreq_q <= '0;
        else          dreq_q <= DREQ;
    end

    // Software requests bypass both the mask and the polarity adjustment.
    always_comb begin
        req = ((dreq_q ^ {NCH{commandReg[6]}}) & ~maskReg) | requestReg;
    end

    always_comb begin
        int unsigned cand;
        pick_ch    = '0;
        pick_found = 1'b0;
        cand       = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = (int'(prio_ptr) + i) % NCH;
            if (!pick_found && req[cand[PW-1:0]]) begin
                pick_ch    = cand[PW-1:0];
                pick_found = 1'b1;
            end
        end
    end

`ifdef DMA_ROTATE_PRIORITY_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prio_ptr <= '0;
        end else if (state == RELEASE) begin
            if (commandReg[4]) begin
                prio_ptr <= PW'((int'(grant_ch) + 1) % NCH);
            end else begin
                prio_ptr <= '0;
            end
        end
    end
    assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};
`else
    always_comb prio_ptr = '0;
    assign unused_cmd = ^{commandReg[5], commandReg[4], commandReg[3], commandReg[1:0]};
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            HRQ       <= 1'b0;
            validDreq <= '0;
            activeCh  <= '0;
            busy      <= 1'b0;
            grant_ch  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!commandReg[2] && pick_found) begin
                        grant_ch <= pick_ch;
                        activeCh <= pick_ch;
                        HRQ      <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // Grant stays locked here; only its own request dropping cancels it.
                    if (HLDA) begin
                        validDreq <= NCH'(1) << grant_ch;
                        state     <= SERVICE;
                    end else if (!req[grant_ch]) begin
                        HRQ   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (cycleDone) begin
                        HRQ       <= 1'b0;
                        validDreq <= '0;
                        state     <= RELEASE;
                    end else if (!HLDA) begin
                        HRQ       <= 1'b0;
                        validDreq <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                RELEASE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    HRQ       <= 1'b0;
                    validDreq <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            DACK[i] = (state == SERVICE && grant_ch == PW'(i)) ? commandReg[7] : ~commandReg[7];
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Randomized self-checking bench for dma_channel_arbiter against a transaction-level model.
module tb_dma_channel_arbiter;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       HLDA;
    logic       cycleDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [3:0] validDreq;
    logic [1:0] activeCh;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] ptr_m = 2'd0;
`ifdef DMA_ROTATE_PRIORITY_EN
    bit         rot_en = 1'b1;
`else
    bit         rot_en = 1'b0;
`endif

    dma_channel_arbiter #(.NCH(4)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DREQ       (DREQ),
        .commandReg (commandReg),
        .maskReg    (maskReg),
        .requestReg (requestReg),
        .HLDA       (HLDA),
        .cycleDone  (cycleDone),
        .HRQ        (HRQ),
        .DACK       (DACK),
        .validDreq  (validDreq),
        .activeCh   (activeCh),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // First requesting channel walking up from the pointer, wrapping at 4.
    function automatic logic [1:0] first_req(input logic [3:0] r, input logic [1:0] ptr);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (int'(ptr) + i) % 4;
            if (r[c]) return 2'(c);
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] dack_exp(input logic [7:0] cmd, input bit act, input logic [1:0] g);
        logic [3:0] v;
        v = {4{~cmd[7]}};
        if (act) v[g] = cmd[7];
        return v;
    endfunction

    // ending: 0 cycleDone, 1 cycleDone with HLDA falling, 2 abort, 3 reset in SERVICE
    task automatic transfer(input logic [7:0] cmd, input logic [3:0] mask, input logic [3:0] d,
                            input logic [3:0] r, input int hold, input int ending, input bit lock);
        logic [3:0] idle_lvl;
        logic [3:0] eff;
        logic [1:0] g;
        idle_lvl   = {4{cmd[6]}};
        maskReg    = 4'hF;
        requestReg = 4'h0;
        DREQ       = idle_lvl;
        commandReg = cmd;
        HLDA       = 1'b0;
        cycleDone  = 1'b0;
        tick(); tick();
        maskReg = mask;
        tick();
        check("idle_hrq", HRQ, 0);
        check("idle_dack", DACK, dack_exp(cmd, 0, 0));
        DREQ       = d;
        requestReg = r;
        eff = (r != 0) ? r : ((d ^ idle_lvl) & ~mask);
        if (cmd[2] || eff == 0) begin
            repeat (4) tick();
            check("nogrant_hrq", HRQ, 0);
            check("nogrant_busy", busy, 0);
            DREQ       = idle_lvl;
            requestReg = 4'h0;
            tick(); tick();
            return;
        end
        g = first_req(eff, ptr_m);
        if (r == 0) begin
            tick();
            check("sync_latency_hrq", HRQ, 0);
        end
        tick();
        check("req_hrq", HRQ, 1);
        check("req_busy", busy, 1);
        check("req_dack", DACK, dack_exp(cmd, 0, 0));
        check("req_valid", validDreq, 0);
        if (lock) requestReg = 4'hF;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_hrq", HRQ, 1);
            check("hold_dack", DACK, dack_exp(cmd, 0, 0));
        end
        HLDA = 1'b1;
        tick();
        check("svc_dack", DACK, dack_exp(cmd, 1, g));
        check("svc_valid", validDreq, 4'b0001 << g);
        check("svc_ch", activeCh, g);
        check("svc_hrq", HRQ, 1);
        maskReg    = 4'hF;
        DREQ       = idle_lvl;
        requestReg = 4'h0;
        tick();
        check("svc_masked_dack", DACK, dack_exp(cmd, 1, g));
        case (ending)
            0, 1: begin
                cycleDone = 1'b1;
                if (ending == 1) HLDA = 1'b0;
                tick();
                cycleDone = 1'b0;
                HLDA      = 1'b0;
                check("rel_hrq", HRQ, 0);
                check("rel_valid", validDreq, 0);
                check("rel_dack", DACK, dack_exp(cmd, 0, 0));
                check("rel_busy", busy, 1);
                tick();
                check("post_busy", busy, 0);
                check("post_hrq", HRQ, 0);
                ptr_m = (rot_en && cmd[4]) ? 2'(g + 2'd1) : 2'd0;
            end
            2: begin
                HLDA = 1'b0;
                tick();
                check("abort_hrq", HRQ, 0);
                check("abort_busy", busy, 0);
                check("abort_valid", validDreq, 0);
                check("abort_dack", DACK, dack_exp(cmd, 0, 0));
            end
            default: begin
                RESET_N = 1'b0;
                tick();
                check("rst_hrq", HRQ, 0);
                check("rst_valid", validDreq, 0);
                check("rst_ch", activeCh, 0);
                check("rst_busy", busy, 0);
                check("rst_dack", DACK, dack_exp(cmd, 0, 0));
                RESET_N = 1'b1;
                HLDA    = 1'b0;
                ptr_m   = 2'd0;
                tick();
            end
        endcase
    endtask

    initial begin
        RESET_N    = 1'b0;
        DREQ       = 4'h0;
        commandReg = 8'h00;
        maskReg    = 4'h0;
        requestReg = 4'h0;
        HLDA       = 1'b0;
        cycleDone  = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        tick();
        check("reset_hrq", HRQ, 0);
        check("reset_dack", DACK, 4'hF);
        check("reset_valid", validDreq, 0);
        check("reset_busy", busy, 0);

        transfer(8'h00, 4'h0, 4'b1010, 4'h0, 2, 0, 0);
        transfer(8'h00, 4'h0, 4'b1000, 4'h0, 0, 0, 0);
        for (int k = 0; k < 5; k++) transfer(8'h10, 4'h0, 4'hF, 4'h0, 0, 0, 0);
        transfer(8'hC0, 4'h0, 4'b1110, 4'h0, 1, 0, 0);
        transfer(8'h00, 4'hF, 4'hF, 4'h0, 0, 0, 0);
        transfer(8'h00, 4'hF, 4'hF, 4'b0100, 0, 0, 0);
        transfer(8'h10, 4'h0, 4'b0110, 4'h0, 1, 0, 0);
        transfer(8'h10, 4'h0, 4'b0110, 4'h0, 1, 2, 0);
        transfer(8'h10, 4'h0, 4'b0110, 4'h0, 0, 1, 1);
        transfer(8'h10, 4'h0, 4'b1111, 4'h0, 0, 3, 0);
        transfer(8'h04, 4'h0, 4'hF, 4'h0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] cmd;
            logic [3:0] r;
            cmd = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0,
                   1'($urandom_range(7, 0) == 0), 2'b00};
            r   = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
            transfer(cmd, 4'($urandom), 4'($urandom), r, int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
